// File: rtl/timer_bus_pkg.sv
// timer_bus_pkg: op codes, FSM states, register map and default timing for the timer bus initiator
package timer_bus_pkg;
    localparam logic [1:0] OP_WR   = 2'b00;
    localparam logic [1:0] OP_RD   = 2'b01;
    localparam logic [1:0] OP_POLL = 2'b10;
    localparam logic [1:0] OP_RSV  = 2'b11;

    localparam logic [1:0] ADDR_CTRL   = 2'd0;
    localparam logic [1:0] ADDR_PERIOD = 2'd1;
    localparam logic [1:0] ADDR_STATUS = 2'd2;
    localparam logic [1:0] ADDR_COUNT  = 2'd3;

    localparam int          DEF_RD_LATENCY  = 1;
    localparam int          DEF_POLL_GAP    = 0;
    localparam logic [31:0] POLL_TIMEOUT_1S = 32'h02FA_F080;

    typedef enum logic [2:0] {IDLE, WR, RD, RD_WAIT, GAP, RESP} state_t;
endpackage

// File: rtl/timeout_counter.sv
// timeout_counter: 32-bit saturating cycle counter with clear, enable and reached-limit flag
// Ports: clk, reset (async high); clr zeroes the count, en advances it; reached = count >= LIMIT.
module timeout_counter #(
    parameter logic [31:0] LIMIT = 32'hFFFF_FFFF
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic reached
);
    logic [31:0] cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (en && cnt != 32'hFFFF_FFFF)
            cnt <= cnt + 32'd1;
    end

    assign reached = cnt >= LIMIT;
endmodule

// File: rtl/timer_bus_initiator.sv
// timer_bus_initiator: turns write/read/poll commands into timer32 register bus strobes
// Ports: clk, reset (async high); cmd_* valid/ready command in; rsp_* one-cycle response pulse;
//        bus_addr/bus_din/bus_wren/bus_rden drive the slave, bus_dout is its read data.
module timer_bus_initiator
    import timer_bus_pkg::*;
#(
    parameter int          RD_LATENCY   = DEF_RD_LATENCY,
    parameter int          POLL_GAP     = DEF_POLL_GAP,
    parameter logic [31:0] POLL_TIMEOUT = POLL_TIMEOUT_1S
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [1:0]  cmd_op,
    input  logic [1:0]  cmd_addr,
    input  logic [31:0] cmd_wdata,
    input  logic [31:0] cmd_mask,
    input  logic [31:0] cmd_match,
    output logic        rsp_valid,
    output logic [31:0] rsp_data,
    output logic        rsp_err,
    output logic [1:0]  bus_addr,
    output logic [31:0] bus_din,
    output logic        bus_wren,
    output logic        bus_rden,
    input  logic [31:0] bus_dout
);
    state_t      state;
    logic [1:0]  op_q;
    logic [31:0] mask_q;
    logic [31:0] match_q;
    logic [1:0]  wait_cnt;
    logic [7:0]  gap_cnt;
    logic        timed_out;
    logic        sample;
    logic        hit;

    assign cmd_ready = (state == IDLE) && !reset;
    // bus_dout is valid in the RD cycle itself for zero latency, else on the last RD_WAIT cycle
    assign sample = (state == RD && RD_LATENCY == 0) || (state == RD_WAIT && wait_cnt == 2'd0);
    assign hit = (bus_dout & mask_q) == match_q;

    // cleared on accept, counts every busy cycle so the budget starts at T+1
    timeout_counter #(.LIMIT(POLL_TIMEOUT)) u_timeout (
        .clk(clk),
        .reset(reset),
        .clr(cmd_valid && cmd_ready),
        .en(state != IDLE),
        .reached(timed_out)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
            op_q <= OP_WR;
            mask_q <= '0;
            match_q <= '0;
            wait_cnt <= '0;
            gap_cnt <= '0;
            bus_addr <= '0;
            bus_din <= '0;
            bus_wren <= 1'b0;
            bus_rden <= 1'b0;
            rsp_valid <= 1'b0;
            rsp_data <= '0;
            rsp_err <= 1'b0;
        end else if (sample) begin
            bus_rden <= 1'b0;
            // a match wins over an expired budget; plain reads always finish here
            if (op_q == OP_RD || hit || timed_out) begin
                state <= RESP;
                rsp_valid <= 1'b1;
                rsp_data <= bus_dout;
                rsp_err <= (op_q != OP_RD) && !hit;
            end else if (POLL_GAP == 0) begin
                state <= RD;
                bus_rden <= 1'b1;
            end else begin
                state <= GAP;
                gap_cnt <= 8'(POLL_GAP - 1);
            end
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op_q <= cmd_op;
                    mask_q <= cmd_mask;
                    match_q <= cmd_match;
                    bus_addr <= cmd_addr;
                    state <= cmd_op == OP_WR ? WR : cmd_op == OP_RSV ? RESP : RD;
                    bus_wren <= cmd_op == OP_WR;
                    bus_din <= cmd_op == OP_WR ? cmd_wdata : '0;
                    bus_rden <= cmd_op == OP_RD || cmd_op == OP_POLL;
                    rsp_valid <= cmd_op == OP_RSV;
                    rsp_err <= cmd_op == OP_RSV;
                end
                WR: begin
                    state <= RESP;
                    bus_wren <= 1'b0;
                    bus_din <= '0;
                    rsp_valid <= 1'b1;
                    rsp_data <= bus_din;
                end
                RD: begin
                    state <= RD_WAIT;
                    bus_rden <= 1'b0;
                    wait_cnt <= 2'(RD_LATENCY - 1);
                end
                RD_WAIT: wait_cnt <= wait_cnt - 2'd1;
                GAP: if (gap_cnt == 8'd0) begin
                    state <= RD;
                    bus_rden <= 1'b1;
                end else begin
                    gap_cnt <= gap_cnt - 8'd1;
                end
                RESP: begin
                    state <= IDLE;
                    bus_addr <= '0;
                    rsp_valid <= 1'b0;
                    rsp_data <= '0;
                    rsp_err <= 1'b0;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_timer_bus_initiator.sv
// tb_timer_bus_initiator: scoreboard bench for timer_bus_initiator with directed command vectors
module tb_timer_bus_initiator;
    import timer_bus_pkg::*;

    typedef struct {
        int          dut;
        int          cyc;
        logic [31:0] data;
        logic        err;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [1:0]  cmd_op = '0;
    logic [1:0]  cmd_addr = '0;
    logic [31:0] cmd_wdata = '0;
    logic [31:0] cmd_mask = '0;
    logic [31:0] cmd_match = '0;
    logic        a_valid = 1'b0;
    logic        b_valid = 1'b0;
    logic        a_ready, b_ready, a_rsp_valid, b_rsp_valid, a_rsp_err, b_rsp_err;
    logic        a_wren, b_wren, a_rden, b_rden;
    logic [31:0] a_rsp_data, b_rsp_data, a_din, b_din, a_dout, b_dout;
    logic [1:0]  a_addr, b_addr;
    logic [31:0] regs [4] = '{default: '0};
    int          cyc = 0;
    int          ntests = 0;
    int          nfail = 0;
    int          a_rd_cnt = 0;
    int          a_last = 0;
    int          a_gap = 0;
    int          rise_base = 0;
    bit          rise_en = 1'b0;
    exp_t        exp_q[$];

    always #5 clk = ~clk;

    timer_bus_initiator #(.RD_LATENCY(1), .POLL_GAP(2), .POLL_TIMEOUT(32'd20)) dut_a (
        .clk(clk), .reset(reset), .cmd_valid(a_valid), .cmd_ready(a_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .cmd_match(cmd_match), .rsp_valid(a_rsp_valid), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err),
        .bus_addr(a_addr), .bus_din(a_din), .bus_wren(a_wren), .bus_rden(a_rden), .bus_dout(a_dout)
    );

    timer_bus_initiator #(.RD_LATENCY(0), .POLL_GAP(0)) dut_b (
        .clk(clk), .reset(reset), .cmd_valid(b_valid), .cmd_ready(b_ready),
        .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_mask(cmd_mask),
        .cmd_match(cmd_match), .rsp_valid(b_rsp_valid), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err),
        .bus_addr(b_addr), .bus_din(b_din), .bus_wren(b_wren), .bus_rden(b_rden), .bus_dout(b_dout)
    );

    // slave for A: one-cycle registered read; optionally raises status bit2 after the 2nd read
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (a_wren) regs[a_addr] <= a_din;
        if (a_rden) begin
            a_dout <= regs[a_addr];
            a_rd_cnt <= a_rd_cnt + 1;
            a_gap <= cyc - a_last;
            a_last <= cyc;
            if (rise_en && a_rd_cnt == rise_base + 1) regs[2] <= regs[2] | 32'h4;
        end
    end

    // slave for B: zero-latency combinational read
    assign b_dout = regs[b_addr];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        ntests++;
        if (act !== req) begin
            nfail++;
            $display("FAIL %s: got %h, required %h", name, act, req);
        end
    endtask

    task automatic check_rsp(input int d, input logic [31:0] data, input logic err);
        exp_t e;
        if (exp_q.size() == 0) begin
            ntests++;
            nfail++;
            $display("FAIL unexpected_rsp: dut %0d got data %h err %b, required no response", d, data, err);
        end else begin
            e = exp_q.pop_front();
            chk("rsp_dut", d, e.dut);
            chk("rsp_cycle", cyc, e.cyc);
            chk("rsp_data", data, e.data);
            chk("rsp_err", {31'd0, err}, {31'd0, e.err});
        end
    endtask

    always @(negedge clk) begin
        if (a_rsp_valid) check_rsp(0, a_rsp_data, a_rsp_err);
        if (b_rsp_valid) check_rsp(1, b_rsp_data, b_rsp_err);
        chk("wren_rden_overlap", {31'd0, a_wren & a_rden}, 32'd0);
        chk("din_outside_wr", a_wren ? 32'd0 : a_din, 32'd0);
    end

    task automatic issue(input bit d, input logic [1:0] op, input logic [1:0] addr,
                         input logic [31:0] wd, input logic [31:0] mk, input logic [31:0] mt,
                         input int lat, input logic [31:0] rdata, input logic rerr,
                         input bit push, output int t);
        int n = 0;
        @(negedge clk);
        cmd_op = op;
        cmd_addr = addr;
        cmd_wdata = wd;
        cmd_mask = mk;
        cmd_match = mt;
        if (d) b_valid = 1'b1;
        else a_valid = 1'b1;
        while (!(d ? b_ready : a_ready) && n < 50) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_accepted", {31'd0, d ? b_ready : a_ready}, 32'd1);
        t = cyc;
        if (push) exp_q.push_back('{int'(d), t + lat, rdata, rerr});
        @(posedge clk);
        #1;
        a_valid = 1'b0;
        b_valid = 1'b0;
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            #1;
            n++;
        end
        chk("queue_drained", exp_q.size(), 32'd0);
    endtask

    initial begin
        int t, t2, base;
        repeat (3) @(negedge clk);
        chk("rst_ready", {31'd0, a_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("rst_strobes", {30'd0, a_wren, a_rden}, 32'd0);
        chk("rst_addr", {30'd0, a_addr}, 32'd0);
        reset = 1'b0;
        #1;
        chk("ready_after_rst", {31'd0, a_ready}, 32'd1);

        // write: strobe at T+1, response at T+2
        issue(0, OP_WR, ADDR_PERIOD, 32'h017D_783F, '0, '0, 2, 32'h017D_783F, 1'b0, 1, t);
        chk("wr_wren", {31'd0, a_wren}, 32'd1);
        chk("wr_addr", {30'd0, a_addr}, 32'd1);
        chk("wr_din", a_din, 32'h017D_783F);
        @(posedge clk);
        #1;
        chk("wr_wren_one_cycle", {31'd0, a_wren}, 32'd0);
        drain();

        // read with latency 1 then latency 0
        issue(0, OP_WR, ADDR_STATUS, 32'hA5A5_A5A5, '0, '0, 2, 32'hA5A5_A5A5, 1'b0, 1, t);
        issue(0, OP_RD, ADDR_STATUS, '0, '0, '0, 3, 32'hA5A5_A5A5, 1'b0, 1, t);
        chk("rd_rden", {31'd0, a_rden}, 32'd1);
        drain();
        issue(1, OP_RD, ADDR_STATUS, '0, '0, '0, 2, 32'hA5A5_A5A5, 1'b0, 1, t);
        drain();

        // poll that matches on the 3rd read
        issue(0, OP_WR, ADDR_STATUS, 32'h10, '0, '0, 2, 32'h10, 1'b0, 1, t);
        drain();
        base = a_rd_cnt;
        rise_base = a_rd_cnt;
        rise_en = 1'b1;
        issue(0, OP_POLL, ADDR_STATUS, '0, 32'h4, 32'h4, 11, 32'h14, 1'b0, 1, t);
        drain();
        rise_en = 1'b0;
        chk("poll_rd_count", a_rd_cnt - base, 32'd3);
        chk("poll_last_rd_cycle", a_last, t + 9);
        chk("poll_rd_spacing", a_gap, 32'd4);

        // poll whose match has a bit outside the mask: times out at counter 21
        base = a_rd_cnt;
        issue(0, OP_POLL, ADDR_STATUS, '0, 32'h4, 32'h8, 23, 32'h14, 1'b1, 1, t);
        drain();
        repeat (10) @(negedge clk);
        chk("timeout_rd_count", a_rd_cnt - base, 32'd6);
        chk("timeout_last_rd_cycle", a_last, t + 21);

        // reserved op, then back-to-back write accepted at T+2
        issue(0, OP_RSV, ADDR_CTRL, '0, '0, '0, 1, 32'd0, 1'b1, 1, t);
        chk("rsv_no_strobe", {30'd0, a_wren, a_rden}, 32'd0);
        issue(0, OP_WR, ADDR_CTRL, 32'h1234_5678, '0, '0, 2, 32'h1234_5678, 1'b0, 1, t2);
        chk("rsv_back_to_back", t2 - t, 32'd2);
        drain();

        // reset in RD_WAIT of a poll: dropped without a response
        base = a_rd_cnt;
        issue(0, OP_POLL, ADDR_STATUS, '0, 32'h4, 32'h8, 0, 32'd0, 1'b0, 0, t);
        @(posedge clk);
        #2;
        reset = 1'b1;
        #1;
        chk("arst_strobes", {30'd0, a_wren, a_rden}, 32'd0);
        chk("arst_rsp_valid", {31'd0, a_rsp_valid}, 32'd0);
        chk("arst_addr", {30'd0, a_addr}, 32'd0);
        chk("arst_ready", {31'd0, a_ready}, 32'd0);
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        #1;
        chk("arst_ready_after", {31'd0, a_ready}, 32'd1);
        repeat (40) @(negedge clk);
        chk("arst_no_more_reads", a_rd_cnt - base, 32'd1);
        chk("final_queue_empty", exp_q.size(), 32'd0);

        $display("[TB] %0d tests run, %0d failed", ntests, nfail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation exceeded its time limit");
        $fatal(1);
    end
endmodule

// File: doc/timer_bus_initiator.md
Name: timer_bus_initiator

Overview:
- Bus initiator for the 4-word timer32-style register slave interface (addr[1:0], din, dout, wren, rden).
- Accepts write, read and poll commands from an upstream controller over a valid/ready handshake.
- Drives single-cycle register strobes and returns one response pulse per accepted command.
- Poll repeats reads until a masked compare matches or a cycle timeout expires; this lets the top level program periods and wait on timer status bits without a CPU.

Parameters:
- RD_LATENCY, 1, cycles from bus_rden high to bus_dout valid (legal 0..3).
- POLL_GAP, 0, idle cycles between consecutive poll reads (legal 0..255).
- POLL_TIMEOUT, 32'h02FAF080, poll budget in clk cycles counted from command accept (1 s at 50 MHz).

Ports:
- clk  input  1  system clock (50 MHz domain).
- reset  input  1  asynchronous, active-high reset.
- cmd_valid  input  1  command present.
- cmd_ready  output  1  initiator can accept; high only in IDLE and not in reset.
- cmd_op  input  2  00 write, 01 read, 10 poll, 11 reserved.
- cmd_addr  input  2  register address.
- cmd_wdata  input  32  write data.
- cmd_mask  input  32  poll compare mask.
- cmd_match  input  32  poll compare value.
- rsp_valid  output  1  one-cycle response pulse; no backpressure.
- rsp_data  output  32  write: echoed wdata; read/poll: sampled dout.
- rsp_err  output  1  poll timeout or reserved op.
- bus_addr  output  2  slave addr.
- bus_din  output  32  slave din.
- bus_wren  output  1  slave write strobe.
- bus_rden  output  1  slave read strobe.
- bus_dout  input  32  slave read data.

Behaviour:
- Reset (asynchronous): state IDLE; all outputs 0; timeout counter 0. An in-flight command is dropped with no response. Strobes fall immediately on reset assertion.
- States: IDLE, WR, RD, RD_WAIT, GAP, RESP.
- Accept: cmd_valid && cmd_ready at cycle T. Latch addr/wdata/mask/match/op. bus_addr holds cmd_addr from T+1 until return to IDLE.
- Write: T+1 in WR with bus_wren=1 and bus_din=wdata, for one cycle. T+2 RESP: rsp_valid=1, rsp_data=wdata, rsp_err=0. T+3 IDLE.
- Read: T+1 in RD with bus_rden=1 for one cycle. Sample bus_dout at T+1+RD_LATENCY (RD_LATENCY=0 samples in the RD cycle). Response at T+2+RD_LATENCY.
- Poll:
  - Same read sequence as Read. After each sample, compare (sample & mask) == match.
  - Match: RESP with data=sample, err=0.
  - No match and counter < POLL_TIMEOUT: wait POLL_GAP cycles in GAP, then re-enter RD.
  - Counter >= POLL_TIMEOUT at compare: RESP with err=1, data=last sample.
  - Match takes priority over timeout in the same cycle.
  - The timeout counter increments every cycle from T+1 and saturates at 32'hFFFFFFFF.
- Reserved op: T+1 RESP with err=1, data=0. No bus strobe.
- Invariants:
  - bus_wren and bus_rden are never high together.
  - bus_din=0 except in WR.
  - rsp_valid is high exactly one cycle per accepted command.
  - cmd_ready=0 from T+1 until back in IDLE.
- Mask bits: if match has bits outside mask, poll never matches and must time out.
- cmd inputs are ignored while cmd_ready=0.

Decomposition:
- Package timer_bus_pkg holds:
  - op code constants OP_WR/OP_RD/OP_POLL/OP_RSV;
  - state encoding;
  - register address constants ADDR_CTRL=0, ADDR_PERIOD=1, ADDR_STATUS=2, ADDR_COUNT=3;
  - default 50 MHz timing constants.
- One sub-module, timeout_counter: 32-bit saturating counter with clear, enable and a compare-reached flag.

Test Plan:
- Write addr=1, wdata=32'h017D783F -> bus_wren one cycle at T+1 with bus_addr=1 and bus_din=32'h017D783F; rsp_valid at T+2 with rsp_data=32'h017D783F, rsp_err=0.
- Read addr=2, RD_LATENCY=1, slave returns 32'hA5A5A5A5 one cycle after rden -> rsp_valid at T+3, rsp_data=32'hA5A5A5A5, rsp_err=0; repeat with RD_LATENCY=0 -> rsp at T+2.
- Poll addr=2, mask=32'h4, match=32'h4, POLL_GAP=2, slave bit2 rises before the 3rd read -> exactly 3 rden pulses spaced 4 cycles apart; rsp_err=0; rsp_data bit2=1.
- Poll with mask=32'h4, match=32'h8, POLL_TIMEOUT=20 -> rsp_err=1 at the first compare where counter >= 20; no further rden afterwards.
- Assert reset during RD_WAIT of a poll -> strobes and rsp_valid 0 asynchronously; no response after release; cmd_ready=1 on the first cycle after reset deasserts.
- cmd_op=11 -> rsp_valid at T+1 with rsp_err=1 and rsp_data=0; no wren/rden at any point; back-to-back command accepted at T+2.
